uart_rx_status_decoder: RTL

//  Receive end of the sensor-status UART link. Deserialises the 8N1 stream and parses the
//  6-byte status frame 'a',LED,'b',BUZ,'c',SEG. Presents the last valid led/buzzer/seg7

---
 rtl/uart_rx_status_decoder_pkg.sv | 23 ++
 rtl/uart_rx_8n1.sv | 111 +++++++++++
 rtl/uart_rx_status_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_status_decoder_pkg.sv
// Shared definitions for the sensor-status UART receiver: frame tags, reset
// seven-segment pattern, and the receiver and parser state encodings.
package uart_rx_status_decoder_pkg;

    localparam logic [7:0] TAG_LED = 8'h61;
    localparam logic [7:0] TAG_BUZ = 8'h62;
    localparam logic [7:0] TAG_SEG = 8'h63;
    localparam logic [6:0] SEG_0   = 7'b0000001;

    typedef enum logic [2:0] {
        P_IDLE, P_LED, P_B, P_BUZ, P_C, P_SEG
    } pstate_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rxstate_e;

    // Boolean value bytes are strictly 0x00 or 0x01
    function automatic logic is_bool(input logic [7:0] b);
        return (b[7:1] == 7'd0);
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, break recovery after
// a bad stop bit. Companion of uart_tx_8n1 on the transmit side.
module uart_rx_8n1
    import uart_rx_status_decoder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err,
    output logic       rx_idle
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic          sync1_q, sync2_q, prev_q;
    rxstate_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          vld_q, vld_d;
    logic          serr_q, serr_d;

    // prev_q trails the synchronised line by one cycle for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            serr_q  <= serr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        serr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        data_d  = shift_q;
                        vld_d   = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        serr_d  = 1'b1;
                        state_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                cnt_d = '0;
                if (sync2_q) state_d = RX_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    assign byte_valid = vld_q;
    assign byte_data  = data_q;
    assign stop_err   = serr_q;
    assign rx_idle    = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_rx_status_decoder.sv
// Status-frame decoder on top of uart_rx_8n1: parses 'a',LED,'b',BUZ,'c',SEG.
// Optional partial-frame timeout enabled by `define UART_RX_TIMEOUT_EN.
module uart_rx_status_decoder
    import uart_rx_status_decoder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       led,
    output logic       buzzer,
    output logic [6:0] seg7,
    output logic       frame_valid,
    output logic       frame_err
);
    logic stop_err, rx_idle, tmo_hit;

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err),
        .rx_idle    (rx_idle)
    );

    pstate_e    p_q, p_d;
    logic       led_sh_q, led_sh_d, buz_sh_q, buz_sh_d;
    logic       led_q, led_d, buz_q, buz_d;
    logic [6:0] seg_q, seg_d;
    logic       fv_q, fv_d, fe_q, fe_d;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TMO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TMO_CLKS);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_run;

    // Only idle gaps inside a partial frame count; any start bit restarts the wait
    assign to_run  = (p_q != P_IDLE) && rx_idle;
    assign tmo_hit = to_run && (to_cnt_q == TW'(TMO_CLKS - 1));

    always_comb begin
        to_cnt_d = '0;
        if (to_run && !tmo_hit) to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q      <= P_IDLE;
            led_sh_q <= 1'b0;
            buz_sh_q <= 1'b0;
            led_q    <= 1'b0;
            buz_q    <= 1'b0;
            seg_q    <= SEG_0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            p_q      <= p_d;
            led_sh_q <= led_sh_d;
            buz_sh_q <= buz_sh_d;
            led_q    <= led_d;
            buz_q    <= buz_d;
            seg_q    <= seg_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
        end
    end

    always_comb begin
        logic bad;
        p_d      = p_q;
        led_sh_d = led_sh_q;
        buz_sh_d = buz_sh_q;
        led_d    = led_q;
        buz_d    = buz_q;
        seg_d    = seg_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        bad      = 1'b0;
        if (stop_err) begin
            fe_d = 1'b1;
            p_d  = P_IDLE;
        end else if (byte_valid) begin
            case (p_q)
                P_IDLE: if (byte_data == TAG_LED) p_d = P_LED;
                P_LED: begin
                    if (is_bool(byte_data)) begin
                        led_sh_d = byte_data[0];
                        p_d      = P_B;
                    end else bad = 1'b1;
                end
                P_B:   if (byte_data == TAG_BUZ) p_d = P_BUZ; else bad = 1'b1;
                P_BUZ: begin
                    if (is_bool(byte_data)) begin
                        buz_sh_d = byte_data[0];
                        p_d      = P_C;
                    end else bad = 1'b1;
                end
                P_C:   if (byte_data == TAG_SEG) p_d = P_SEG; else bad = 1'b1;
                P_SEG: begin
                    if (!byte_data[7]) begin
                        led_d = led_sh_q;
                        buz_d = buz_sh_q;
                        seg_d = byte_data[6:0];
                        fv_d  = 1'b1;
                        p_d   = P_IDLE;
                    end else bad = 1'b1;
                end
                default: p_d = P_IDLE;
            endcase
            // A stray 'a' is taken as the start of a fresh frame
            if (bad) begin
                fe_d = 1'b1;
                p_d  = (byte_data == TAG_LED) ? P_LED : P_IDLE;
            end
        end else if (tmo_hit) begin
            fe_d = 1'b1;
            p_d  = P_IDLE;
        end
    end

    assign led         = led_q;
    assign buzzer      = buz_q;
    assign seg7        = seg_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;

endmodule
